// File: rtl/sdram_responder.sv
// sdram_responder: device-side model of a 16-bit SDR SDRAM backed by block RAM.
// Decodes controller commands on every rising clock edge and returns read data
// with the programmed CAS latency, burst length/type and DQM masking.
// Optional build macro SDRAM_TIMING_CHECK_EN adds per-bank tRCD/tRP/tRC
// checking reported on err[4]; without it err[4] is constant 0.
module sdram_responder #(
  parameter int unsigned MEM_AW = 12,
  parameter int unsigned COL_W  = 9,
  parameter int unsigned ROW_W  = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SDRAM_nCS,
  input  logic        SDRAM_nRAS,
  input  logic        SDRAM_nCAS,
  input  logic        SDRAM_nWE,
  input  logic [1:0]  SDRAM_BA,
  input  logic [12:0] SDRAM_A,
  input  logic        SDRAM_DQML,
  input  logic        SDRAM_DQMH,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic [4:0]  err,
  output logic [15:0] ref_cnt
);

  typedef enum logic [2:0] {
    CmdNop, CmdActive, CmdRead, CmdWrite, CmdBst, CmdPre, CmdRef, CmdLmr
  } cmd_e;

  cmd_e w_cmd;

  // Mode register
  logic       r_mode_valid;
  logic [2:0] r_bl;
  logic       r_bt;
  logic       r_cl3;
  logic       r_single_wr;

  // Bank state
  logic [3:0]       r_bank_act;
  logic [ROW_W-1:0] r_bank_row [4];

  // Burst engine (holds words 1..N-1; word 0 is served on the command edge)
  logic             r_bst_act;
  logic             r_bst_wr;
  logic             r_bst_ap;
  logic             r_bst_bt;
  logic             r_bst_full;
  logic [1:0]       r_bst_ba;
  logic [ROW_W-1:0] r_bst_row;
  logic [COL_W-1:0] r_bst_col;
  logic [COL_W-1:0] r_bst_mask;
  logic [COL_W-1:0] r_bst_idx;
  logic [COL_W-1:0] r_bst_last;

  // Backing store and read pipe
  logic [15:0] r_mem [2**MEM_AW];
  logic [15:0] r_mem_q;
  logic        r_v1;
  logic        r_v2;
  logic [15:0] r_d2;
  logic [1:0]  r_dqm_q;

  logic [3:0]  r_err;
  logic [15:0] r_ref_cnt;
  logic        w_err4;

  logic [COL_W-1:0] w_mode_mask;
  logic             w_mode_full;
  logic             w_is_rw;
  logic             w_rw_ok;
  logic             w_new_wr;
  logic             w_new_single;
  logic [COL_W-1:0] w_new_mask;
  logic             w_new_full;
  logic             w_new_multi;
  logic             w_interrupt;
  logic             w_cont;
  logic             w_burst_done;
  logic [COL_W-1:0] w_bst_off;
  logic [COL_W-1:0] w_bst_col;
  logic             w_acc_en;
  logic             w_acc_wr;
  logic [1:0]       w_acc_ba;
  logic [ROW_W-1:0] w_acc_row;
  logic [COL_W-1:0] w_acc_col;
  logic [MEM_AW-1:0] w_addr;
  logic             w_rd_fire;
  logic             w_src_v;
  logic [15:0]      w_src_d;

  // Command decode; nCS high falls into the NOP default
  always_comb begin
    w_cmd = CmdNop;
    case ({SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE})
      4'b0011: w_cmd = CmdActive;
      4'b0101: w_cmd = CmdRead;
      4'b0100: w_cmd = CmdWrite;
      4'b0110: w_cmd = CmdBst;
      4'b0010: w_cmd = CmdPre;
      4'b0001: w_cmd = CmdRef;
      4'b0000: w_cmd = CmdLmr;
      default: w_cmd = CmdNop;
    endcase
  end

  // Burst-length code to column wrap mask (length-1); reserved codes act as BL1
  always_comb begin
    w_mode_mask = '0;
    w_mode_full = 1'b0;
    case (r_bl)
      3'd1: w_mode_mask = COL_W'(1);
      3'd2: w_mode_mask = COL_W'(3);
      3'd3: w_mode_mask = COL_W'(7);
      3'd7: begin
        w_mode_mask = '1;
        w_mode_full = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_is_rw      = (w_cmd == CmdRead) || (w_cmd == CmdWrite);
  assign w_rw_ok      = w_is_rw && r_mode_valid && r_bank_act[SDRAM_BA];
  assign w_new_wr     = (w_cmd == CmdWrite);
  assign w_new_single = w_new_wr && r_single_wr;
  assign w_new_mask   = w_new_single ? '0 : w_mode_mask;
  assign w_new_full   = !w_new_single && w_mode_full;
  assign w_new_multi  = (w_new_mask != '0);

  // Any new column command, BST, or a precharge hitting the burst bank stops the burst
  assign w_interrupt  = w_is_rw || (w_cmd == CmdBst) ||
                        ((w_cmd == CmdPre) && (SDRAM_A[10] || (SDRAM_BA == r_bst_ba)));
  assign w_cont       = r_bst_act && !w_interrupt;
  assign w_burst_done = w_cont && !r_bst_full && (r_bst_idx == r_bst_last);

  assign w_bst_off = r_bst_bt ? (r_bst_col ^ r_bst_idx) : (r_bst_col + r_bst_idx);
  assign w_bst_col = (r_bst_col & ~r_bst_mask) | (w_bst_off & r_bst_mask);

  // Select the word accessed this edge: a fresh command or the next burst word
  always_comb begin
    w_acc_en  = 1'b0;
    w_acc_wr  = 1'b0;
    w_acc_ba  = SDRAM_BA;
    w_acc_row = r_bank_row[SDRAM_BA];
    w_acc_col = SDRAM_A[COL_W-1:0];
    if (w_rw_ok) begin
      w_acc_en = 1'b1;
      w_acc_wr = w_new_wr;
    end else if (w_cont) begin
      w_acc_en  = 1'b1;
      w_acc_wr  = r_bst_wr;
      w_acc_ba  = r_bst_ba;
      w_acc_row = r_bst_row;
      w_acc_col = w_bst_col;
    end
  end

  assign w_addr    = MEM_AW'({w_acc_ba, w_acc_row, w_acc_col});
  assign w_rd_fire = w_acc_en && !w_acc_wr;

  // Backing store with byte write enables; never reset
  always_ff @(posedge clk) begin
    if (w_acc_en && w_acc_wr && !SDRAM_DQML) r_mem[w_addr][7:0]  <= dq_in[7:0];
    if (w_acc_en && w_acc_wr && !SDRAM_DQMH) r_mem[w_addr][15:8] <= dq_in[15:8];
    r_mem_q <= r_mem[w_addr];
  end

  // Open-row storage per bank
  always_ff @(posedge clk) begin
    if (!reset && (w_cmd == CmdActive) && r_mode_valid) begin
      r_bank_row[SDRAM_BA] <= SDRAM_A[ROW_W-1:0];
    end
  end

  // Bank open/closed state, including auto-precharge after the last word
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bank_act <= '0;
    end else begin
      if (w_burst_done && r_bst_ap) r_bank_act[r_bst_ba] <= 1'b0;
      case (w_cmd)
        CmdActive: if (r_mode_valid) r_bank_act[SDRAM_BA] <= 1'b1;
        CmdPre: begin
          if (SDRAM_A[10]) r_bank_act <= '0;
          else             r_bank_act[SDRAM_BA] <= 1'b0;
        end
        CmdRead, CmdWrite: begin
          if (w_rw_ok && !w_new_multi && SDRAM_A[10]) r_bank_act[SDRAM_BA] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Burst engine sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bst_act  <= 1'b0;
      r_bst_wr   <= 1'b0;
      r_bst_ap   <= 1'b0;
      r_bst_bt   <= 1'b0;
      r_bst_full <= 1'b0;
      r_bst_ba   <= '0;
      r_bst_row  <= '0;
      r_bst_col  <= '0;
      r_bst_mask <= '0;
      r_bst_idx  <= '0;
      r_bst_last <= '0;
    end else if (w_rw_ok) begin
      r_bst_act  <= w_new_multi;
      r_bst_wr   <= w_new_wr;
      r_bst_ap   <= SDRAM_A[10];
      r_bst_bt   <= r_bt && !w_new_full;
      r_bst_full <= w_new_full;
      r_bst_ba   <= SDRAM_BA;
      r_bst_row  <= r_bank_row[SDRAM_BA];
      r_bst_col  <= SDRAM_A[COL_W-1:0];
      r_bst_mask <= w_new_mask;
      r_bst_idx  <= COL_W'(1);
      r_bst_last <= w_new_mask;
    end else if (w_interrupt) begin
      r_bst_act <= 1'b0;
    end else if (w_cont) begin
      if (w_burst_done) r_bst_act <= 1'b0;
      else              r_bst_idx <= r_bst_idx + COL_W'(1);
    end
  end

  // CAS-latency pipe: stage 1 is the BRAM output, stage 2 adds one more clock for CL3
  always_comb begin
    w_src_v = r_cl3 ? r_v2 : r_v1;
    w_src_d = r_cl3 ? r_d2 : r_mem_q;
  end

  // Read output register; DQM registered here gives the two-clock read mask latency
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_d2    <= '0;
      r_dqm_q <= '0;
      dq_oe   <= 1'b0;
      dq_out  <= '0;
    end else begin
      r_v1    <= w_rd_fire;
      r_v2    <= r_v1;
      r_d2    <= r_mem_q;
      r_dqm_q <= {SDRAM_DQMH, SDRAM_DQML};
      dq_oe   <= w_src_v && !(&r_dqm_q);
      if (w_src_v) begin
        dq_out <= {r_dqm_q[1] ? 8'h00 : w_src_d[15:8], r_dqm_q[0] ? 8'h00 : w_src_d[7:0]};
      end else begin
        dq_out <= '0;
      end
    end
  end

  // Mode register, refresh counter and sticky protocol errors
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode_valid <= 1'b0;
      r_bl         <= '0;
      r_bt         <= 1'b0;
      r_cl3        <= 1'b0;
      r_single_wr  <= 1'b0;
      r_err        <= '0;
      r_ref_cnt    <= '0;
    end else begin
      if (w_cmd == CmdLmr) begin
        r_mode_valid <= 1'b1;
        r_bl         <= SDRAM_A[2:0];
        r_bt         <= SDRAM_A[3];
        r_cl3        <= (SDRAM_A[6:4] == 3'd3);
        r_single_wr  <= SDRAM_A[9];
        if ((SDRAM_A[6:4] != 3'd2) && (SDRAM_A[6:4] != 3'd3)) r_err[2] <= 1'b1;
      end
      if (w_cmd == CmdRef) begin
        r_ref_cnt <= r_ref_cnt + 16'd1;
        if (|r_bank_act) r_err[3] <= 1'b1;
      end
      if (((w_cmd == CmdActive) || w_is_rw) && !r_mode_valid) r_err[2] <= 1'b1;
      if (w_is_rw && r_mode_valid && !r_bank_act[SDRAM_BA]) r_err[0] <= 1'b1;
      if ((w_cmd == CmdActive) && r_mode_valid && r_bank_act[SDRAM_BA]) r_err[1] <= 1'b1;
    end
  end

`ifdef SDRAM_TIMING_CHECK_EN
  // Ages count edges since the last ACTIVE / PRECHARGE per bank, saturating at 7;
  // command distance in clocks is age + 1.
  logic [2:0] r_act_age [4];
  logic [2:0] r_pre_age [4];
  logic       r_terr;
  logic       w_terr;

  // Timing violation detect for the command on this edge
  always_comb begin
    w_terr = 1'b0;
    case (w_cmd)
      CmdActive: begin
        if (r_mode_valid) begin
          w_terr = (r_pre_age[SDRAM_BA] < 3'd1) || (r_act_age[SDRAM_BA] < 3'd5);
        end
      end
      CmdRead, CmdWrite: begin
        if (w_rw_ok) w_terr = (r_act_age[SDRAM_BA] < 3'd1);
      end
      CmdRef: begin
        for (int b = 0; b < 4; b++) begin
          if (r_act_age[b] < 3'd5) w_terr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Per-bank age counters and sticky timing flag
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 4; b++) begin
        r_act_age[b] <= 3'd7;
        r_pre_age[b] <= 3'd7;
      end
      r_terr <= 1'b0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (r_act_age[b] != 3'd7) r_act_age[b] <= r_act_age[b] + 3'd1;
        if (r_pre_age[b] != 3'd7) r_pre_age[b] <= r_pre_age[b] + 3'd1;
        if ((w_cmd == CmdPre) && (SDRAM_A[10] || (SDRAM_BA == 2'(b)))) r_pre_age[b] <= '0;
      end
      if ((w_cmd == CmdActive) && r_mode_valid) r_act_age[SDRAM_BA] <= '0;
      if (w_terr) r_terr <= 1'b1;
    end
  end

  assign w_err4 = r_terr;
`else
  assign w_err4 = 1'b0;
`endif

  assign err     = {w_err4, r_err};
  assign ref_cnt = r_ref_cnt;

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: init, single read/write, byte masks,
// CL3 sequential burst wrap, protocol error flags and optional timing checks.
module tb_sdram_responder;

  localparam logic [3:0] CNop = 4'b0111;
  localparam logic [3:0] CAct = 4'b0011;
  localparam logic [3:0] CRd  = 4'b0101;
  localparam logic [3:0] CWr  = 4'b0100;
  localparam logic [3:0] CPre = 4'b0010;
  localparam logic [3:0] CRef = 4'b0001;
  localparam logic [3:0] CLmr = 4'b0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        n_cs, n_ras, n_cas, n_we;
  logic [1:0]  ba;
  logic [12:0] addr;
  logic        dqml, dqmh;
  logic [15:0] dq_in;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic [4:0]  err;
  logic [15:0] ref_cnt;

  int n_pass  = 0;
  int n_total = 0;
  logic [4:0] exp_t;

  sdram_responder dut (
    .clk        (clk),
    .reset      (reset),
    .SDRAM_nCS  (n_cs),
    .SDRAM_nRAS (n_ras),
    .SDRAM_nCAS (n_cas),
    .SDRAM_nWE  (n_we),
    .SDRAM_BA   (ba),
    .SDRAM_A    (addr),
    .SDRAM_DQML (dqml),
    .SDRAM_DQMH (dqmh),
    .dq_in      (dq_in),
    .dq_out     (dq_out),
    .dq_oe      (dq_oe),
    .err        (err),
    .ref_cnt    (ref_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Drive one command for the next rising edge; returns at the following falling edge
  task automatic issue(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a,
                       input logic [1:0] dqm, input logic [15:0] d);
    {n_cs, n_ras, n_cas, n_we} = c;
    ba = b;
    addr = a;
    {dqmh, dqml} = dqm;
    dq_in = d;
    @(negedge clk);
    {n_cs, n_ras, n_cas, n_we} = CNop;
    {dqmh, dqml} = 2'b00;
    addr = '0;
  endtask

  task automatic nops(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    nops(2);
    reset = 1'b0;
  endtask

  task automatic init_dev();
    issue(CPre, 2'd0, 13'h400, 2'b00, 16'h0);
    for (int i = 0; i < 8; i++) issue(CRef, 2'd0, 13'h0, 2'b00, 16'h0);
    issue(CLmr, 2'd0, 13'h220, 2'b00, 16'h0);
  endtask

  initial begin
    {n_cs, n_ras, n_cas, n_we} = CNop;
    ba = '0; addr = '0; dqml = 1'b0; dqmh = 1'b0; dq_in = '0;
    @(negedge clk);
    do_reset();
    check("rst_dq_out", 32'(dq_out), 32'h0);
    check("rst_dq_oe", 32'(dq_oe), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_ref_cnt", 32'(ref_cnt), 32'h0);

    init_dev();
    check("init_ref_cnt", 32'(ref_cnt), 32'd8);
    check("init_err", 32'(err), 32'h0);

    // Single write then read, CL2
    issue(CAct, 2'd1, 13'd5, 2'b00, 16'h0);
    nops(1);
    issue(CWr, 2'd1, 13'd3, 2'b00, 16'hA55A);
    issue(CRd, 2'd1, 13'd3, 2'b00, 16'h0);
    nops(1);
    check("rd_oe", 32'(dq_oe), 32'h1);
    check("rd_data", 32'(dq_out), 32'hA55A);

    // High byte masked on write
    issue(CWr, 2'd1, 13'd8, 2'b00, 16'hFFFF);
    issue(CWr, 2'd1, 13'd8, 2'b10, 16'h1234);
    issue(CRd, 2'd1, 13'd8, 2'b00, 16'h0);
    nops(1);
    check("wr_mask_data", 32'(dq_out), 32'hFF34);
    check("wr_mask_oe", 32'(dq_oe), 32'h1);

    // Read DQM blanks the word two clocks later
    issue(CRd, 2'd1, 13'd8, 2'b11, 16'h0);
    nops(1);
    check("rd_dqm_oe", 32'(dq_oe), 32'h0);

    // CL3 BL4 sequential burst starting mid-block
    for (int k = 4; k < 8; k++) issue(CWr, 2'd1, 13'(k), 2'b00, 16'(k));
    issue(CLmr, 2'd0, 13'h032, 2'b00, 16'h0);
    issue(CRd, 2'd1, 13'd6, 2'b00, 16'h0);
    nops(1);
    check("bst_oe_early", 32'(dq_oe), 32'h0);
    nops(1);
    check("bst_w0", {15'h0, dq_oe, dq_out}, {15'h0, 1'b1, 16'd6});
    nops(1);
    check("bst_w1", {15'h0, dq_oe, dq_out}, {15'h0, 1'b1, 16'd7});
    nops(1);
    check("bst_w2", {15'h0, dq_oe, dq_out}, {15'h0, 1'b1, 16'd4});
    nops(1);
    check("bst_w3", {15'h0, dq_oe, dq_out}, {15'h0, 1'b1, 16'd5});
    nops(1);
    check("bst_end_oe", 32'(dq_oe), 32'h0);

    // Protocol errors
    issue(CRd, 2'd2, 13'd0, 2'b00, 16'h0);
    nops(2);
    check("idle_rd_oe", 32'(dq_oe), 32'h0);
    check("idle_rd_err", 32'(err), 32'h01);
    nops(1);
    check("idle_rd_oe2", 32'(dq_oe), 32'h0);
    issue(CAct, 2'd1, 13'd7, 2'b00, 16'h0);
    check("dbl_act_err", 32'(err), 32'h03);
    nops(6);
    issue(CRef, 2'd0, 13'h0, 2'b00, 16'h0);
    check("ref_open_err", 32'(err), 32'h0B);
    check("ref_cnt9", 32'(ref_cnt), 32'd9);

    do_reset();
    check("rst2_err", 32'(err), 32'h0);
    check("rst2_ref_cnt", 32'(ref_cnt), 32'h0);
    check("rst2_oe", 32'(dq_oe), 32'h0);

    // ACTIVE before LOAD_MODE
    issue(CAct, 2'd0, 13'd1, 2'b00, 16'h0);
    check("no_mode_err", 32'(err), 32'h04);

    // READ one clock after ACTIVE violates tRCD when checking is built in
`ifdef SDRAM_TIMING_CHECK_EN
    exp_t = 5'h10;
`else
    exp_t = 5'h00;
`endif
    do_reset();
    issue(CPre, 2'd0, 13'h400, 2'b00, 16'h0);
    issue(CLmr, 2'd0, 13'h220, 2'b00, 16'h0);
    issue(CAct, 2'd0, 13'd1, 2'b00, 16'h0);
    issue(CRd, 2'd0, 13'd0, 2'b00, 16'h0);
    check("trcd_short", 32'(err), 32'(exp_t));

    do_reset();
    issue(CPre, 2'd0, 13'h400, 2'b00, 16'h0);
    issue(CLmr, 2'd0, 13'h220, 2'b00, 16'h0);
    issue(CAct, 2'd0, 13'd1, 2'b00, 16'h0);
    nops(1);
    issue(CRd, 2'd0, 13'd0, 2'b00, 16'h0);
    check("trcd_ok", 32'(err), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
